// File: rtl/imem_loader.sv
// Byte-stream program loader: takes a little-endian length header and then words,
// writes each word into instruction memory, and holds the pc paused until the image is complete.
module imem_loader #(
  parameter int unsigned          XLEN      = 32,
  parameter logic [XLEN-1:0]      BASE_ADDR = 32'h0000_0000,
  parameter int unsigned          MAX_WORDS = 1024
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [7:0]      in_data,
  output logic            mem_write_en,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_data,
  output logic            pause,
  output logic            busy,
  output logic            done,
  output logic            error
);

  localparam int unsigned IDX_W = $clog2(MAX_WORDS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_WRITE,
    S_DONE
  } state_e;

  state_e            state_q,     state_d;
  logic [1:0]        byte_cnt_q,  byte_cnt_d;
  logic [23:0]       shift_q,     shift_d;
  logic [31:0]       len_q,       len_d;
  logic [IDX_W-1:0]  word_idx_q,  word_idx_d;
  logic              in_ready_q,  in_ready_d;
  logic              pause_q,     pause_d;
  logic              busy_q,      busy_d;
  logic              done_q,      done_d;
  logic              error_q,     error_d;
  logic              mem_we_q,    mem_we_d;
  logic [XLEN-1:0]   mem_addr_q,  mem_addr_d;
  logic [XLEN-1:0]   mem_data_q,  mem_data_d;

  logic              byte_fire;
  logic [31:0]       assembled;
  logic              last_word;

  // The 4th byte is combined with the three already shifted in, so no extra cycle is spent.
  assign byte_fire = in_valid & in_ready_q;
  assign assembled = {in_data, shift_q};
  assign last_word = ((32'(word_idx_q) + 32'd1) == len_q);

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    len_d      = len_q;
    word_idx_d = word_idx_q;
    in_ready_d = in_ready_q;
    pause_d    = pause_q;
    busy_d     = busy_q;
    done_d     = done_q;
    error_d    = error_q;
    mem_we_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_LEN;
          in_ready_d = 1'b1;
          pause_d    = 1'b1;
          busy_d     = 1'b1;
          done_d     = 1'b0;
          error_d    = 1'b0;
          byte_cnt_d = 2'd0;
          word_idx_d = '0;
          len_d      = 32'd0;
        end
      end

      S_LEN: begin
        if (byte_fire) begin
          shift_d    = {in_data, shift_q[23:8]};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            len_d = assembled;
            if (assembled == 32'd0) begin
              state_d    = S_DONE;
              in_ready_d = 1'b0;
              done_d     = 1'b1;
              pause_d    = 1'b0;
              busy_d     = 1'b0;
            end else if (assembled > 32'(MAX_WORDS)) begin
              state_d    = S_IDLE;
              in_ready_d = 1'b0;
              error_d    = 1'b1;
              pause_d    = 1'b0;
              busy_d     = 1'b0;
            end else begin
              state_d = S_DATA;
            end
          end
        end
      end

      S_DATA: begin
        if (byte_fire) begin
          shift_d    = {in_data, shift_q[23:8]};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            state_d    = S_WRITE;
            in_ready_d = 1'b0;
            mem_we_d   = 1'b1;
            mem_addr_d = BASE_ADDR + XLEN'({word_idx_q, 2'b00});
            mem_data_d = XLEN'(assembled);
          end
        end
      end

      S_WRITE: begin
        word_idx_d = word_idx_q + IDX_W'(1);
        if (last_word) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          pause_d = 1'b0;
          busy_d  = 1'b0;
        end else begin
          state_d    = S_DATA;
          in_ready_d = 1'b1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d    = S_IDLE;
        in_ready_d = 1'b0;
        pause_d    = 1'b0;
        busy_d     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      byte_cnt_q <= 2'd0;
      shift_q    <= 24'd0;
      len_q      <= 32'd0;
      word_idx_q <= '0;
      in_ready_q <= 1'b0;
      pause_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
      len_q      <= len_d;
      word_idx_q <= word_idx_d;
      in_ready_q <= in_ready_d;
      pause_q    <= pause_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign pause        = pause_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;
  assign mem_write_en = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_data     = mem_data_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: a stream-level model predicts the write list and final status,
// a negedge monitor checks every write strobe against it.
module tb_imem_loader;

  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int unsigned MAXW = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic        mem_write_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic        pause, busy, done, error;

  imem_loader #(.XLEN(32), .BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .mem_write_en(mem_write_en), .mem_addr(mem_addr),
    .mem_data(mem_data), .pause(pause), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [7:0]  stream[$];
  wr_t         exp_q[$];
  wr_t         log_q[$];
  bit          prev_we = 1'b0;
  bit          e_done, e_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Write monitor: every strobe must match the next predicted write, last one cycle, with in_ready low.
  always @(negedge clk) begin
    if (rst && mem_write_en) begin
      wr_t e;
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got addr 0x%08h data 0x%08h, none expected", mem_addr, mem_data);
      end else begin
        e = exp_q.pop_front();
        if (mem_addr !== e.a || mem_data !== e.d) begin
          n_fail++;
          $display("FAIL write: got 0x%08h@0x%08h expected 0x%08h@0x%08h", mem_data, mem_addr, e.d, e.a);
        end
      end
      log_q.push_back({mem_addr, mem_data});
      chk("ready_low_in_write", 32'(in_ready), 32'd0);
      chk("strobe_one_cycle", 32'(prev_we), 32'd0);
    end
    prev_we = rst && mem_write_en;
  end

  // Model: decode header from the stream and predict writes and final status.
  task automatic model_load();
    logic [31:0] n;
    n = {stream[3], stream[2], stream[1], stream[0]};
    e_done = 1'b0;
    e_err  = 1'b0;
    log_q.delete();
    if (n > 32'(MAXW)) begin
      e_err = 1'b1;
    end else begin
      e_done = 1'b1;
      for (int w = 0; w < int'(n); w++) begin
        exp_q.push_back({BASE + 32'(4 * w),
                         {stream[4*w+7], stream[4*w+6], stream[4*w+5], stream[4*w+4]}});
      end
    end
  endtask

  task automatic set_normal();
    logic [7:0] b[12];
    b = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'hB3, 8'h05, 8'hB5, 8'h00};
    stream.delete();
    foreach (b[k]) stream.push_back(b[k]);
  endtask

  task automatic set_header(input logic [7:0] b0, input logic [7:0] b1);
    stream.delete();
    stream.push_back(b0);
    stream.push_back(b1);
    stream.push_back(8'h00);
    stream.push_back(8'h00);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_pause", 32'(pause), 32'd1);
    chk("start_ready", 32'(in_ready), 32'd1);
    chk("start_clears_error", 32'(error), 32'd0);
    chk("start_clears_done", 32'(done), 32'd0);
  endtask

  // Drives stream bytes; returns right after the edge that consumed the last byte sent.
  task automatic send(input bit gaps, input int start_at, input int stop_after);
    int i = 0;
    int cyc = 0;
    int stall = 0;
    bit v, rdy;
    while (i < stream.size() && i < stop_after) begin
      @(negedge clk);
      v = gaps ? ((cyc % 2) == 0) : 1'b1;
      cyc++;
      in_valid = v;
      in_data  = stream[i];
      start    = (i == start_at);
      rdy      = in_ready;
      @(posedge clk);
      if (v && rdy) begin
        i++;
        stall = 0;
      end else begin
        stall++;
        if (stall > 40) begin
          n_tests++;
          n_fail++;
          $display("FAIL stream_timeout: byte %0d not accepted after %0d cycles, expected acceptance", i, stall);
          break;
        end
      end
    end
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  // Checks the final status of a normal two-word load, starting at the negedge after the last byte.
  task automatic finish_normal();
    @(negedge clk);
    idle_inputs();
    chk("last_strobe", 32'(mem_write_en), 32'd1);
    chk("not_done_during_write", 32'(done), 32'd0);
    @(negedge clk);
    chk("done", 32'(done), 32'(e_done));
    chk("error", 32'(error), 32'(e_err));
    chk("pause_released", 32'(pause), 32'd0);
    chk("busy_released", 32'(busy), 32'd0);
    chk("all_writes_seen", 32'(exp_q.size()), 32'd0);
    chk("write_count", 32'(log_q.size()), 32'd2);
    if (log_q.size() == 2) begin
      chk("w0_addr", log_q[0].a, 32'h0000_0000);
      chk("w0_data", log_q[0].d, 32'h0010_0513);
      chk("w1_addr", log_q[1].a, 32'h0000_0004);
      chk("w1_data", log_q[1].d, 32'h00B5_05B3);
    end
    @(negedge clk);
    chk("done_sticky", 32'(done), 32'd1);
    chk("idle_ready_low", 32'(in_ready), 32'd0);
    chk("addr_held", mem_addr, 32'h0000_0004);
    chk("data_held", mem_data, 32'h00B5_05B3);
  endtask

  initial begin
    // Reset with start asserted: reset wins.
    start = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_we", 32'(mem_write_en), 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_data", mem_data, 32'd0);
    chk("rst_flags", {28'd0, pause, busy, done, error}, 32'd0);
    start = 1'b0;
    rst   = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_after_rst_busy", 32'(busy), 32'd0);

    // Normal load.
    set_normal();
    model_load();
    pulse_start();
    send(1'b0, -1, 1000);
    finish_normal();

    // Zero length.
    set_header(8'h00, 8'h00);
    model_load();
    pulse_start();
    send(1'b0, -1, 1000);
    @(negedge clk);
    idle_inputs();
    chk("zero_done", 32'(done), 32'(e_done));
    chk("zero_error", 32'(error), 32'd0);
    chk("zero_ready", 32'(in_ready), 32'd0);
    chk("zero_no_write", 32'(log_q.size()), 32'd0);

    // Over-limit header (N = 1025).
    set_header(8'h01, 8'h04);
    model_load();
    pulse_start();
    send(1'b0, -1, 1000);
    @(negedge clk);
    idle_inputs();
    chk("over_error", 32'(error), 32'(e_err));
    chk("over_done", 32'(done), 32'd0);
    chk("over_ready", 32'(in_ready), 32'd0);
    chk("over_busy", 32'(busy), 32'd0);
    chk("over_pause", 32'(pause), 32'd0);
    chk("over_no_write", 32'(log_q.size()), 32'd0);

    // Backpressure: new start clears error, in_valid toggles every other cycle.
    set_normal();
    model_load();
    pulse_start();
    send(1'b1, -1, 1000);
    finish_normal();

    // Reset after two bytes of the second word.
    set_normal();
    model_load();
    pulse_start();
    send(1'b0, -1, 10);
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    #1;
    chk("midrst_outputs", {27'd0, in_ready, pause, busy, done, error}, 32'd0);
    chk("midrst_we", 32'(mem_write_en), 32'd0);
    chk("midrst_pending", 32'(exp_q.size()), 32'd1);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    chk("midrst_one_write", 32'(log_q.size()), 32'd1);
    set_normal();
    model_load();
    pulse_start();
    send(1'b0, -1, 1000);
    finish_normal();

    // Start pulsed during DATA is ignored.
    set_normal();
    model_load();
    pulse_start();
    send(1'b0, 6, 1000);
    finish_normal();

    repeat (2) @(negedge clk);
    chk("no_stray_writes", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer-side counterpart to the instruction fetch path. Receives a byte stream over a valid/ready interface and assembles little-endian 32-bit words.
- Writes each word into instruction memory through a single-cycle write port.
- Holds the pc in pause while loading, so the core fetches only after the program image is complete.

Parameters:
XLEN, 32, data word width; fixed at 32 for this block
BASE_ADDR, 32'h0000_0000, byte address of the first written word
MAX_WORDS, 1024, largest accepted word count; larger headers are rejected

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-low
start  input  1  one-cycle pulse; begins a load from IDLE
in_valid  input  1  byte present on in_data
in_ready  output  1  loader can accept a byte this cycle
in_data  input  8  stream byte
mem_write_en  output  1  write strobe to instruction memory
mem_addr  output  XLEN  byte address of the write
mem_data  output  XLEN  assembled word
pause  output  1  to pc pause; high while loading
busy  output  1  high from accepted start until DONE
done  output  1  sticky; high after a successful load until next start
error  output  1  sticky; high after a rejected header until next start

Behaviour:
- Reset (rst low, asynchronous): state IDLE; all outputs 0; byte counter, word index and length cleared. Any partial word is discarded and no write is issued.
- Handshake: a byte is consumed only on a rising edge with in_valid & in_ready. in_valid while in_ready=0 is ignored and the byte is not consumed. in_ready is a registered function of state only and never depends on in_valid.
- States:
  - IDLE: in_ready=0, pause=0, busy=0. On start, clear done/error, set pause=1, busy=1, go to LEN.
  - LEN: in_ready=1. Accept 4 bytes into the length N, little-endian: first byte goes to bits 7:0.
    - After the 4th byte, if N==0: go to DONE.
    - If N>MAX_WORDS: set error=1, pause=0, busy=0, go to IDLE.
    - Otherwise go to DATA.
  - DATA: in_ready=1. Accept 4 bytes into the word shift register, little-endian. After the 4th byte go to WRITE.
  - WRITE: in_ready=0. mem_write_en=1 for exactly this one cycle, with mem_addr = BASE_ADDR + 4*word_idx and mem_data = assembled word. Then increment word_idx. If word_idx+1==N go to DONE, else go to DATA.
  - DONE: one cycle. done=1, pause=0, busy=0, then go to IDLE. done stays high in IDLE.
- Latency: the write strobe appears the cycle after the edge that accepts the 4th byte of a word. Minimum 5 cycles per word with in_valid held high.
- mem_addr/mem_data hold their last values when mem_write_en=0. Only mem_write_en qualifies them.
- Address arithmetic is modulo 2^XLEN; wrap is permitted and not flagged.
- start in any state other than IDLE is ignored.
- start coincident with rst low: reset wins.
- Gaps in in_valid stall the byte counter indefinitely; there is no timeout.

Test Plan:
- Normal load: rst low→high, start, stream 02 00 00 00 13 05 10 00 B3 05 B5 00 with in_valid always high → writes of 0x00100513 @0x0 and 0x00B505B3 @0x4, each 1-cycle strobe. Then done=1, pause=0, busy=0.
- Zero length: start, then bytes 00 00 00 00 → no mem_write_en, done=1 one cycle after the 4th byte, error=0.
- Over-limit: start, then bytes 01 04 00 00 (N=1025) → error=1, done=0, no writes, in_ready=0, back in IDLE. A new start clears error.
- Backpressure/gaps: toggle in_valid every other cycle during the normal load → identical writes and addresses. No byte is consumed while in_ready=0 during WRITE: in_valid held high there must not advance the counter.
- Reset mid-load: assert rst after 2 bytes of the second word → all outputs 0 immediately, no second write. A fresh start and full stream then loads correctly from BASE_ADDR.
- Start while busy: pulse start during DATA → no restart; word_idx and the byte sequence are unaffected, and the final done is the same as in the normal load.
